memoria_programa_loader: RTL and testbench

Avalon-MM master that fills and checks the 64 KiB × 8 single-port program memory of the Nios II SSD system. A byte stream (UART or JTAG bridge) feeds it, and it writes the bytes to consecutive addresses (LOAD). It can instead read the memory back and compare it against the stream (VERIFY). It drives the memory's `s1` port directly and owns that port while busy.

---
 rtl/memoria_programa_loader_if.sv | 36 +++
 rtl/memoria_programa_loader.sv | 113 +++++++++++
 tb/tb_memoria_programa_loader.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memoria_programa_loader_if.sv
// Control, byte-stream and Avalon-MM s1 signals shared by the program-memory loader
// and whatever drives it (bridge + memory side).
interface memoria_programa_loader_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [7:0]        avm_writedata;
    logic              avm_clken;
    logic [7:0]        avm_readdata;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] err_addr;
    logic [ADDR_W:0]   count;

    modport master (
        input  start, mode, base_addr, length, in_data, in_valid, avm_readdata,
        output in_ready, avm_address, avm_chipselect, avm_write, avm_writedata, avm_clken,
               busy, done, error, err_addr, count
    );

    modport slave (
        output start, mode, base_addr, length, in_data, in_valid, avm_readdata,
        input  in_ready, avm_address, avm_chipselect, avm_write, avm_writedata, avm_clken,
               busy, done, error, err_addr, count
    );
endinterface

// File: rtl/memoria_programa_loader.sv
// Avalon-MM master that LOADs a byte stream into program memory or VERIFYs memory
// against it, one byte per cycle, with a READ_LATENCY-aware compare pipeline.
module memoria_programa_loader #(
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    memoria_programa_loader_if.master bus
);
    localparam int STAGES = READ_LATENCY;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t            state_q;
    logic              mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        wdata_q;
    logic              cs_q;
    logic              wr_q;
    logic              done_q;
    logic              error_q;
    logic [ADDR_W-1:0] err_addr_q;

    // Stage STAGES of the compare pipeline lines up with avm_readdata.
    logic [STAGES:0]             vld_pipe;
    logic [STAGES:0][7:0]        exp_pipe;
    logic [STAGES:0][ADDR_W-1:0] adr_pipe;

    logic in_ready;
    logic xfer;
    logic mismatch;

    assign in_ready = (state_q == RUN) && (count_q < len_q);
    assign xfer     = in_ready && bus.in_valid;
    assign count_d  = count_q + (ADDR_W+1)'(1);
    assign addr_d   = base_q + count_q[ADDR_W-1:0];
    assign mismatch = vld_pipe[STAGES] && (bus.avm_readdata != exp_pipe[STAGES]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
            vld_pipe   <= '0;
            exp_pipe   <= '0;
            adr_pipe   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], xfer & mode_q};
            exp_pipe <= {exp_pipe[STAGES-1:0], bus.in_data};
            adr_pipe <= {adr_pipe[STAGES-1:0], addr_d};
            done_q   <= (state_q == FIN);
            cs_q     <= 1'b0;
            wr_q     <= 1'b0;

            // Only the first mismatch address is kept; later ones just hold the flag.
            if (mismatch) begin
                error_q <= 1'b1;
                if (!error_q) err_addr_q <= adr_pipe[STAGES];
            end

            case (state_q)
                IDLE: if (bus.start) begin
                    mode_q     <= bus.mode;
                    base_q     <= bus.base_addr;
                    len_q      <= bus.length;
                    count_q    <= '0;
                    error_q    <= 1'b0;
                    err_addr_q <= '0;
                    state_q    <= (bus.length == '0) ? FIN : RUN;
                end
                RUN: if (xfer) begin
                    addr_q  <= addr_d;
                    cs_q    <= 1'b1;
                    wr_q    <= ~mode_q;
                    if (!mode_q) wdata_q <= bus.in_data;
                    count_q <= count_d;
                    if (count_d == len_q) state_q <= DRAIN;
                end
                // Leave once only the entry being compared this edge remains.
                DRAIN: if (!mode_q || vld_pipe[STAGES-1:0] == '0) state_q <= FIN;
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.avm_address    = addr_q;
    assign bus.avm_chipselect = cs_q;
    assign bus.avm_write      = wr_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.avm_clken      = 1'b1;
    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = done_q;
    assign bus.error          = error_q;
    assign bus.err_addr       = err_addr_q;
    assign bus.count          = count_q;
endmodule

// File: tb/tb_memoria_programa_loader.sv
// Drives two loaders (read latency 1 and 2) with one stimulus stream, each against its own
// memory, and checks them against a byte-array reference of the program memory.
module tb_memoria_programa_loader;
    localparam int AW = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic          start, mode, in_valid;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [7:0]    in_data;

    memoria_programa_loader_if #(.ADDR_W(AW)) b1 ();
    memoria_programa_loader_if #(.ADDR_W(AW)) b2 ();

    memoria_programa_loader #(.ADDR_W(AW), .READ_LATENCY(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    memoria_programa_loader #(.ADDR_W(AW), .READ_LATENCY(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));

    assign b1.start = start;     assign b2.start = start;
    assign b1.mode = mode;       assign b2.mode = mode;
    assign b1.base_addr = base_addr; assign b2.base_addr = base_addr;
    assign b1.length = length;   assign b2.length = length;
    assign b1.in_data = in_data; assign b2.in_data = in_data;
    assign b1.in_valid = in_valid; assign b2.in_valid = in_valid;

    // Memories: synchronous RAM, one and two registered read stages.
    bit [7:0] mem1 [65536];
    bit [7:0] mem2 [65536];
    bit [7:0] rd1, rd2a, rd2b;
    assign b1.avm_readdata = rd1;
    assign b2.avm_readdata = rd2b;
    always @(posedge clk) begin
        if (b1.avm_chipselect && b1.avm_write) mem1[b1.avm_address] <= b1.avm_writedata;
        if (b2.avm_chipselect && b2.avm_write) mem2[b2.avm_address] <= b2.avm_writedata;
        rd1  <= mem1[b1.avm_address];
        rd2a <= mem2[b2.avm_address];
        rd2b <= rd2a;
    end

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor logs (cleared by log_clr).
    logic     log_clr;
    int       wa1[$], wc1[$], ra1[$], d1[$], wa2[$], ra2[$], d2[$], xf[$];
    bit [7:0] wd1[$], wd2[$];
    always @(negedge clk) begin
        if (log_clr) begin
            wa1.delete(); wc1.delete(); ra1.delete(); d1.delete(); wd1.delete();
            wa2.delete(); ra2.delete(); d2.delete(); wd2.delete(); xf.delete();
        end else begin
            if (b1.avm_chipselect) begin
                if (b1.avm_write) begin
                    wa1.push_back(int'(b1.avm_address)); wd1.push_back(b1.avm_writedata); wc1.push_back(cyc);
                end else ra1.push_back(int'(b1.avm_address));
            end
            if (b2.avm_chipselect) begin
                if (b2.avm_write) begin
                    wa2.push_back(int'(b2.avm_address)); wd2.push_back(b2.avm_writedata);
                end else ra2.push_back(int'(b2.avm_address));
            end
            if (b1.done) d1.push_back(cyc);
            if (b2.done) d2.push_back(cyc);
            if (in_valid && b1.in_ready) xf.push_back(cyc);
        end
    end

    int checks = 0;
    int errors = 0;
    int start_cyc;

    logic [7:0] sd[$];
    bit         sv[$];

    // Reference model: program memory contents and expected results of one operation.
    bit [7:0] ref_mem [65536];
    int       exp_wa[$];
    bit [7:0] exp_wd[$];
    bit       exp_err;
    int       exp_ea;

    function automatic void model_op(input bit m, input int b, input int len);
        exp_wa.delete(); exp_wd.delete(); exp_err = 1'b0; exp_ea = 0;
        for (int i = 0; i < len; i++) begin
            int a = (b + i) % 65536;
            if (!m) begin
                exp_wa.push_back(a); exp_wd.push_back(sd[i]); ref_mem[a] = sd[i];
            end else if (ref_mem[a] != sd[i] && !exp_err) begin
                exp_err = 1'b1; exp_ea = a;
            end
        end
    endfunction

    function automatic logic [63:0] outs(input int which);
        if (which == 1)
            return {b1.in_ready, b1.avm_chipselect, b1.avm_write, b1.avm_address, b1.avm_writedata,
                    b1.busy, b1.done, b1.error, b1.err_addr, b1.count, b1.avm_clken};
        return {b2.in_ready, b2.avm_chipselect, b2.avm_write, b2.avm_address, b2.avm_writedata,
                b2.busy, b2.done, b2.error, b2.err_addr, b2.count, b2.avm_clken};
    endfunction

    task automatic clear_logs();
        log_clr = 1'b1;
        @(posedge clk); #1;
        log_clr = 1'b0;
    endtask

    // One operation: start pulse, stream sd[] under the sv[] valid pattern, wait for both dones.
    task automatic run_op(input bit m, input int b, input int len, input bit glitch);
        int  idx, pidx, g;
        bit  x;
        clear_logs();
        start = 1'b1; mode = m; base_addr = AW'(b); length = 17'(len); start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; pidx = 0; g = 0;
        while (idx < len && g < 4000) begin
            in_valid = (sv.size() == 0) ? 1'b1 : sv[pidx % sv.size()];
            in_data  = sd[idx];
            if (glitch && pidx == 2) begin
                start = 1'b1; mode = ~m; base_addr = 16'h5555; length = 17'd1;
            end else begin
                start = 1'b0; mode = m; base_addr = AW'(b); length = 17'(len);
            end
            @(negedge clk); x = in_valid && b1.in_ready;
            @(posedge clk); #1;
            if (x) idx++;
            pidx++; g++;
        end
        start = 1'b0; in_valid = 1'b0;
        g = 0;
        while ((d1.size() == 0 || d2.size() == 0) && g < 100) begin
            @(posedge clk); #1; g++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0;
        in_data = '0; in_valid = 1'b0; log_clr = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (outs(1) !== 64'd1) begin errors++; $display("FAIL reset_outs_rl1: got %h expected %h", outs(1), 64'd1); end
        checks++; if (outs(2) !== 64'd1) begin errors++; $display("FAIL reset_outs_rl2: got %h expected %h", outs(2), 64'd1); end
        reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        checks++; if (outs(1) !== 64'd1) begin errors++; $display("FAIL idle_outs: got %h expected %h", outs(1), 64'd1); end
    endtask

    task automatic test_load_b2b();
        sd = '{8'hAA, 8'h55, 8'h01, 8'hFF}; sv.delete();
        model_op(1'b0, 16'h0010, 4);
        run_op(1'b0, 16'h0010, 4, 1'b0);
        checks++;
        if (wa1.size() !== 4 || wa2.size() !== 4) begin
            errors++; $display("FAIL load_nwrites: got %0d/%0d expected 4", wa1.size(), wa2.size());
        end else for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa1[i] !== exp_wa[i] || wd1[i] !== exp_wd[i] || wa2[i] !== exp_wa[i] || wd2[i] !== exp_wd[i]) begin
                errors++; $display("FAIL load_write%0d: got %h:%h expected %h:%h", i, wa1[i], wd1[i], exp_wa[i], exp_wd[i]);
            end
        end
        checks++; if (wc1.size() != 4 || wc1[3] - wc1[0] !== 3) begin errors++; $display("FAIL load_b2b_span: got %0d writes expected 4 consecutive", wc1.size()); end
        checks++; if (d1.size() !== 1 || d1[0] !== xf[xf.size()-1] + 3) begin errors++; $display("FAIL load_done: got n=%0d at %0d expected 1 at %0d", d1.size(), d1[0], xf[xf.size()-1] + 3); end
        checks++; if (d2.size() !== 1 || d2[0] !== xf[xf.size()-1] + 3) begin errors++; $display("FAIL load_done_rl2: got n=%0d at %0d expected 1 at %0d", d2.size(), d2[0], xf[xf.size()-1] + 3); end
        checks++; if ({b1.count, b1.error} !== {17'd4, 1'b0}) begin errors++; $display("FAIL load_status: got %0d/%0d expected 4/0", b1.count, b1.error); end
    endtask

    task automatic test_verify();
        int last;
        sd = '{8'hAA, 8'h55, 8'h01, 8'hFF}; sv.delete();
        model_op(1'b1, 16'h0010, 4);
        run_op(1'b1, 16'h0010, 4, 1'b0);
        last = xf[xf.size()-1];
        checks++; if ({b1.error, b2.error} !== {exp_err, exp_err}) begin errors++; $display("FAIL verify_match_err: got %b%b expected %b", b1.error, b2.error, exp_err); end
        checks++; if (ra1.size() !== 4 || wa1.size() !== 0 || ra1[0] !== 16'h10 || ra1[3] !== 16'h13) begin errors++; $display("FAIL verify_reads: got %0d reads %0d writes expected 4/0", ra1.size(), wa1.size()); end
        checks++; if (d1.size() !== 1 || d1[0] !== last + 4) begin errors++; $display("FAIL verify_done_rl1: got %0d expected %0d", d1[0], last + 4); end
        checks++; if (d2.size() !== 1 || d2[0] !== last + 5) begin errors++; $display("FAIL verify_done_rl2: got %0d expected %0d", d2[0], last + 5); end

        sd = '{8'hAA, 8'h55, 8'h02, 8'h00};
        model_op(1'b1, 16'h0010, 4);
        run_op(1'b1, 16'h0010, 4, 1'b0);
        checks++; if ({b1.error, b1.err_addr} !== {exp_err, AW'(exp_ea)}) begin errors++; $display("FAIL verify_mis_rl1: got %b@%h expected %b@%h", b1.error, b1.err_addr, exp_err, exp_ea); end
        checks++; if ({b2.error, b2.err_addr} !== {exp_err, AW'(exp_ea)}) begin errors++; $display("FAIL verify_mis_rl2: got %b@%h expected %b@%h", b2.error, b2.err_addr, exp_err, exp_ea); end
        checks++; if (b2.count !== 17'd4) begin errors++; $display("FAIL verify_count: got %0d expected 4", b2.count); end
    endtask

    task automatic test_wrap();
        sd.delete(); sv.delete();
        for (int i = 0; i < 4; i++) sd.push_back(8'($urandom));
        model_op(1'b0, 16'hFFFE, 4);
        run_op(1'b0, 16'hFFFE, 4, 1'b0);
        checks++;
        if (wa1.size() !== 4) begin errors++; $display("FAIL wrap_nwrites: got %0d expected 4", wa1.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (wa1[i] !== exp_wa[i] || wd1[i] !== exp_wd[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, wa1[i], exp_wa[i]); end
        end
        checks++; if (b1.error !== 1'b0) begin errors++; $display("FAIL wrap_error: got %b expected 0", b1.error); end
    endtask

    task automatic test_zero_len();
        sd.delete(); sv.delete();
        run_op(1'b0, 16'h1234, 0, 1'b0);
        checks++; if (wa1.size() + ra1.size() + wa2.size() + ra2.size() !== 0) begin errors++; $display("FAIL zero_cs: got %0d accesses expected 0", wa1.size() + ra1.size()); end
        checks++; if (d1.size() !== 1 || d1[0] !== start_cyc + 2) begin errors++; $display("FAIL zero_done: got n=%0d at %0d expected 1 at %0d", d1.size(), d1[0], start_cyc + 2); end
        checks++; if (b1.count !== '0) begin errors++; $display("FAIL zero_count: got %0d expected 0", b1.count); end
    endtask

    task automatic test_ignored_start();
        sd.delete(); sv.delete();
        for (int i = 0; i < 8; i++) sd.push_back(8'($urandom));
        model_op(1'b0, 16'h0100, 8);
        run_op(1'b0, 16'h0100, 8, 1'b1);
        checks++; if (wa1.size() !== 8 || ra1.size() !== 0 || wa1[7] !== 16'h0107 || wd1[7] !== exp_wd[7]) begin errors++; $display("FAIL ignstart_writes: got %0d writes last %h expected 8 last 0107", wa1.size(), wa1[7]); end
        checks++; if ({d1.size(), b1.count} !== {32'd1, 17'd8}) begin errors++; $display("FAIL ignstart_done: got %0d dones count %0d expected 1/8", d1.size(), b1.count); end
    endtask

    task automatic test_backpressure();
        sd = '{8'h11, 8'h22, 8'h33}; sv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        model_op(1'b0, 16'h0200, 3);
        run_op(1'b0, 16'h0200, 3, 1'b0);
        checks++;
        if (wa1.size() !== 3 || xf.size() !== 3 || ra1.size() !== 0) begin
            errors++; $display("FAIL bp_count: got %0d strobes %0d xfers expected 3/3", wa1.size() + ra1.size(), xf.size());
        end else for (int i = 0; i < 3; i++) begin
            checks++;
            if (wa1[i] !== exp_wa[i] || wd1[i] !== exp_wd[i] || wc1[i] !== xf[i] + 1) begin
                errors++; $display("FAIL bp_write%0d: got %h at %0d expected %h at %0d", i, wa1[i], wc1[i], exp_wa[i], xf[i] + 1);
            end
        end
        checks++; if (d1.size() !== 1 || d1[0] !== xf[2] + 3) begin errors++; $display("FAIL bp_done: got %0d expected %0d", d1[0], xf[2] + 3); end
        sv.delete();
    endtask

    task automatic test_reset_mid();
        int n, g;
        bit x;
        clear_logs();
        start = 1'b1; mode = 1'b0; base_addr = 16'h0300; length = 17'd8;
        @(posedge clk); #1;
        start = 1'b0; n = 0; g = 0;
        while (n < 2 && g < 50) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            @(negedge clk); x = b1.in_ready;
            @(posedge clk); #1;
            if (x) n++;
            g++;
        end
        reset_n = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (outs(1) !== 64'd1 || outs(2) !== 64'd1) begin errors++; $display("FAIL rstmid_outs: got %h expected %h", outs(1), 64'd1); end
        repeat (3) @(posedge clk); #1;
        checks++; if (d1.size() + d2.size() !== 0) begin errors++; $display("FAIL rstmid_nodone: got %0d dones expected 0", d1.size() + d2.size()); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        sd.delete(); sv.delete();
        for (int i = 0; i < 8; i++) sd.push_back(8'($urandom));
        model_op(1'b0, 16'h0300, 8);
        run_op(1'b0, 16'h0300, 8, 1'b0);
        checks++; if (wa1.size() !== 8 || wa1[0] !== 16'h0300 || wd1[0] !== exp_wd[0] || wd1[7] !== exp_wd[7]) begin errors++; $display("FAIL rstmid_reload: got %0d writes expected 8", wa1.size()); end
        checks++; if ({d1.size(), b1.count} !== {32'd1, 17'd8}) begin errors++; $display("FAIL rstmid_done: got %0d dones count %0d expected 1/8", d1.size(), b1.count); end
    endtask

    task automatic test_random();
        int lb = 0, ll = 0;
        for (int k = 0; k < 10; k++) begin
            bit m;
            int b, len, last, n;
            m = (k < 2) ? 1'b0 : 1'($urandom % 2);
            if (m && $urandom % 3 != 0) begin b = lb; len = ll; end
            else begin b = int'($urandom % 65536); len = int'($urandom_range(1, 12)); end
            sd.delete(); sv.delete();
            for (int i = 0; i < len; i++)
                sd.push_back(m ? ref_mem[(b + i) % 65536] : 8'($urandom));
            if (m && $urandom % 2 == 1) begin
                sd[$urandom % len] ^= 8'h5A;
                sd[$urandom % len] ^= 8'h81;
            end
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) sv.push_back(1'($urandom % 2));
            sv[0] = 1'b1;
            model_op(m, b, len);
            if (!m) begin lb = b; ll = len; end
            run_op(m, b, len, 1'b0);
            last = xf[xf.size()-1];
            checks++;
            if (wa1.size() !== exp_wa.size() || ra1.size() !== (m ? len : 0)) begin
                errors++; $display("FAIL rnd%0d_access: got %0d w %0d r expected %0d w %0d r", k, wa1.size(), ra1.size(), exp_wa.size(), m ? len : 0);
            end else for (int i = 0; i < exp_wa.size(); i++) begin
                checks++; if (wa1[i] !== exp_wa[i] || wd1[i] !== exp_wd[i]) begin errors++; $display("FAIL rnd%0d_write%0d: got %h:%h expected %h:%h", k, i, wa1[i], wd1[i], exp_wa[i], exp_wd[i]); end
            end
            checks++; if ({b1.error, b1.err_addr, b2.error, b2.err_addr} !== {exp_err, AW'(exp_ea), exp_err, AW'(exp_ea)}) begin
                errors++; $display("FAIL rnd%0d_err: got %b@%h/%b@%h expected %b@%h", k, b1.error, b1.err_addr, b2.error, b2.err_addr, exp_err, exp_ea);
            end
            checks++; if (b1.count !== 17'(len)) begin errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", k, b1.count, len); end
            checks++; if (d1.size() !== 1 || d1[0] !== last + 3 + int'(m) || d2.size() !== 1 || d2[0] !== last + 3 + 2 * int'(m)) begin
                errors++; $display("FAIL rnd%0d_done: got %0d/%0d expected %0d/%0d", k, d1[0], d2[0], last + 3 + int'(m), last + 3 + 2 * int'(m));
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_b2b();
        test_verify();
        test_wrap();
        test_zero_len();
        test_ignored_start();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
